// File: rtl/vc_arb_pkg.sv
// -----------------------------------------------------------------------------
// vc_arb_pkg
//   Shared definitions for the round-robin register-write arbiter:
//   - idx_width(): index width for a count (never less than 1 bit)
//   - default sizes and their index widths
//   - lock-state encoding (ARB / BURST)
//   - rr_next(): round-robin pointer update after a transfer
// -----------------------------------------------------------------------------
package vc_arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int P_NREQS = 4;
    localparam int P_NREGS = 8;
    localparam int NREQ_W  = idx_width(P_NREQS);
    localparam int NREG_W  = idx_width(P_NREGS);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } lock_state_e;

    // A finished burst hands priority to the requester after the winner;
    // otherwise the pointer holds.
    function automatic int rr_next(input int ptr, input int winner,
                                   input logic release_lock, input int nreqs);
        return release_lock ? ((winner + 1) % nreqs) : ptr;
    endfunction

endpackage

// File: rtl/vc_rr_reg_write_arb_if.sv
// -----------------------------------------------------------------------------
// vc_rr_reg_write_arb_if
//   Bundles the requester write handshake, the read port and the lock status.
//   master : requester side (drives val/addr/data/last and rd_addr)
//   slave  : arbiter side   (drives rdy, rd_data, locked, lock_owner)
// -----------------------------------------------------------------------------
interface vc_rr_reg_write_arb_if
    import vc_arb_pkg::*;
#(
    parameter int p_nreqs = P_NREQS,
    parameter int p_nbits = 32,
    parameter int p_nregs = P_NREGS
);
    localparam int AW = idx_width(p_nregs);
    localparam int RW = idx_width(p_nreqs);

    logic [p_nreqs-1:0]    req_val;
    logic [p_nreqs-1:0]    req_rdy;
    logic [p_nreqs*AW-1:0] req_addr;
    logic [p_nreqs*p_nbits-1:0] req_data;
    logic [p_nreqs-1:0]    req_last;
    logic [AW-1:0]         rd_addr;
    logic [p_nbits-1:0]    rd_data;
    logic                  locked;
    logic [RW-1:0]         lock_owner;

    modport master (
        output req_val, req_addr, req_data, req_last, rd_addr,
        input  req_rdy, rd_data, locked, lock_owner
    );

    modport slave (
        input  req_val, req_addr, req_data, req_last, rd_addr,
        output req_rdy, rd_data, locked, lock_owner
    );
endinterface

// File: rtl/vc_reg_bank.sv
// -----------------------------------------------------------------------------
// vc_reg_bank
//   p_nregs x p_nbits register bank: one write port (one-hot decoded onto the
//   slice enables) and one combinational read port. A read of the address
//   being written returns the old value.
//   clk, reset_n      : clock / async active-low reset
//   wr_en/addr/data   : write port
//   rd_addr, rd_data  : read port
// -----------------------------------------------------------------------------
module vc_reg_bank
    import vc_arb_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter int                 p_nregs       = P_NREGS,
    parameter logic [p_nbits-1:0] p_reset_value = '0,
    localparam int                AW            = idx_width(p_nregs)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [p_nbits-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [p_nbits-1:0] rd_data
);
    logic [p_nregs-1:0] wr_sel;
    logic [p_nbits-1:0] regs [p_nregs];

    genvar gi;
    generate
        for (gi = 0; gi < p_nregs; gi++) begin : g_slice
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));

            vc_reg_slice #(
                .p_nbits       (p_nbits),
                .p_reset_value (p_reset_value)
            ) u_slice (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (wr_sel[gi]),
                .d       (wr_data),
                .q       (regs[gi])
            );
        end
    endgenerate

    assign rd_data = regs[rd_addr];
endmodule

// File: rtl/vc_reg_slice.sv
// -----------------------------------------------------------------------------
// vc_reg_slice
//   One register of the bank: loads d when en is high, async clears to
//   p_reset_value.
//   clk, reset_n : clock / async active-low reset
//   en, d        : write enable and data
//   q            : stored value
// -----------------------------------------------------------------------------
module vc_reg_slice #(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);
    logic [p_nbits-1:0] data_q;
    logic [p_nbits-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= p_reset_value;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;
endmodule

// File: rtl/vc_rr_reg_write_arb.sv
// -----------------------------------------------------------------------------
// vc_rr_reg_write_arb
//   Round-robin arbiter sharing the write port of a small register bank among
//   p_nreqs requesters. A requester keeps the port for a burst until it sends
//   a word with last=1; priority then moves to the next requester.
//   clk, reset_n : clock / async active-low reset
//   bus (slave)  : req_val/rdy/addr/data/last, rd_addr/rd_data,
//                  locked, lock_owner
// -----------------------------------------------------------------------------
module vc_rr_reg_write_arb
    import vc_arb_pkg::*;
#(
    parameter int                 p_nreqs       = P_NREQS,
    parameter int                 p_nbits       = 32,
    parameter int                 p_nregs       = P_NREGS,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vc_rr_reg_write_arb_if.slave  bus
);
    localparam int AW = idx_width(p_nregs);
    localparam int RW = idx_width(p_nreqs);

    logic [RW-1:0] ptr_q,   ptr_d;
    logic [RW-1:0] owner_q, owner_d;
    lock_state_e   lock_q,  lock_d;

    logic [p_nreqs-1:0] grant;
    logic [RW-1:0]      gidx;
    logic               fire;
    logic [AW-1:0]      wr_addr;
    logic [p_nbits-1:0] wr_data;
    int                 idx;

    // Grant: only val is looked at, so rdy never feeds back into itself.
    // Held at zero while reset is asserted so nothing fires in reset.
    always_comb begin
        grant = '0;
        gidx  = '0;
        fire  = 1'b0;
        idx   = 0;
        if (lock_q == BURST) begin
            if (bus.req_val[owner_q]) begin
                grant[owner_q] = 1'b1;
                gidx           = owner_q;
                fire           = 1'b1;
            end
        end else begin
            for (int k = 0; k < p_nreqs; k++) begin
                idx = (int'(ptr_q) + k) % p_nreqs;
                if (!fire && bus.req_val[idx]) begin
                    grant[idx] = 1'b1;
                    gidx       = RW'(idx);
                    fire       = 1'b1;
                end
            end
        end
        if (!reset_n) begin
            grant = '0;
            fire  = 1'b0;
        end
    end

    always_comb begin
        wr_addr = bus.req_addr[int'(gidx)*AW +: AW];
        wr_data = bus.req_data[int'(gidx)*p_nbits +: p_nbits];
    end

    // Lock FSM and pointer update.
    always_comb begin
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        if (fire) begin
            if (bus.req_last[gidx]) begin
                lock_d  = ARB;
                owner_d = '0;
                ptr_d   = RW'(rr_next(int'(ptr_q), int'(gidx), 1'b1, p_nreqs));
            end else begin
                lock_d  = BURST;
                owner_d = gidx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            lock_q  <= ARB;
            owner_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    vc_reg_bank #(
        .p_nbits       (p_nbits),
        .p_nregs       (p_nregs),
        .p_reset_value (p_reset_value)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.req_rdy    = grant;
    assign bus.locked     = (lock_q == BURST);
    assign bus.lock_owner = (lock_q == BURST) ? owner_q : '0;
endmodule

// File: tb/tb_vc_rr_reg_write_arb.sv
module tb_vc_rr_reg_write_arb;
    localparam int NR = 4;
    localparam int NB = 32;
    localparam int NG = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    vc_rr_reg_write_arb_if #(.p_nreqs(NR), .p_nbits(NB), .p_nregs(NG)) bus ();

    vc_rr_reg_write_arb #(
        .p_nreqs       (NR),
        .p_nbits       (NB),
        .p_nregs       (NG),
        .p_reset_value (32'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [NR-1:0] rdy;
        logic          lk;
        logic [1:0]    own;
        logic [NB-1:0] rd;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] ra  [NR];
    logic [NB-1:0] rdd [NR];
    logic [NB-1:0] m_bank [NG];
    int            errors = 0;
    int            checks = 0;
    int            mon_id = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and push the expected observation.
    task automatic drive(input logic [NR-1:0] val, input logic [NR-1:0] last,
                         input logic [AW-1:0] rda, input logic [NR-1:0] exp_rdy,
                         input logic exp_lk, input logic [1:0] exp_own);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = ra[i];
            bus.req_data[i*NB +: NB] = rdd[i];
        end
        bus.req_val  = val;
        bus.req_last = last;
        bus.rd_addr  = rda;
        e.rdy = exp_rdy;
        e.lk  = exp_lk;
        e.own = exp_own;
        e.rd  = m_bank[rda];
        sb.push_back(e);
        for (int i = 0; i < NR; i++)
            if (exp_rdy[i]) m_bank[ra[i]] = rdd[i];
        $display("drive #%0d val=%b last=%b rd_addr=%0d exp_rdy=%b", sb.size() + mon_id, val, last, rda, exp_rdy);
    endtask

    // Monitor: compare settled combinational outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val($sformatf("rdy#%0d", mon_id), 64'(bus.req_rdy), 64'(e.rdy));
                check_val($sformatf("locked#%0d", mon_id), 64'(bus.locked), 64'(e.lk));
                check_val($sformatf("owner#%0d", mon_id), 64'(bus.lock_owner), 64'(e.own));
                check_val($sformatf("rd_data#%0d", mon_id), 64'(bus.rd_data), 64'(e.rd));
                mon_id++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_val  = '0;
        bus.req_last = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.rd_addr  = '0;
        for (int i = 0; i < NR; i++) begin ra[i] = '0; rdd[i] = '0; end
        for (int i = 0; i < NG; i++) m_bank[i] = '0;

        // Reset asserted before any clock edge: outputs must be quiet.
        #1 reset_n = 1'b0;
        bus.req_val = '1;
        #1;
        check_val("rst_rdy", 64'(bus.req_rdy), 64'h0);
        check_val("rst_locked", 64'(bus.locked), 64'h0);
        check_val("rst_owner", 64'(bus.lock_owner), 64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.req_val = '0;
        reset_n = 1'b1;
        for (int a = 0; a < NG; a++) drive('0, '0, AW'(a), '0, 1'b0, 2'd0);

        // Round-robin fairness.
        for (int i = 0; i < NR; i++) begin ra[i] = AW'(i); rdd[i] = 32'h100 + i; end
        for (int c = 0; c < 8; c++) drive('1, '1, 3'd0, 4'b0001 << (c % 4), 1'b0, 2'd0);
        for (int a = 0; a < 4; a++) drive('0, '0, AW'(a), '0, 1'b0, 2'd0);

        // Burst lock: req0 three words to addr 5, req1 waiting.
        ra[0] = 3'd5; rdd[0] = 32'hA; ra[1] = 3'd6; rdd[1] = 32'h66;
        drive(4'b0011, 4'b0010, 3'd5, 4'b0001, 1'b0, 2'd0);
        rdd[0] = 32'hB;
        drive(4'b0011, 4'b0010, 3'd5, 4'b0001, 1'b1, 2'd0);
        rdd[0] = 32'hC;
        drive(4'b0011, 4'b0011, 3'd5, 4'b0001, 1'b1, 2'd0);
        drive(4'b0011, 4'b0011, 3'd5, 4'b0010, 1'b0, 2'd0);
        drive('0, '0, 3'd6, '0, 1'b0, 2'd0);

        // Owner bubble: req2 locks, idles two cycles, req3 must wait.
        ra[2] = 3'd2; rdd[2] = 32'h21; ra[3] = 3'd7; rdd[3] = 32'h77;
        drive(4'b1100, 4'b1000, 3'd2, 4'b0100, 1'b0, 2'd0);
        drive(4'b1000, 4'b1000, 3'd2, 4'b0000, 1'b1, 2'd2);
        drive(4'b1000, 4'b1000, 3'd2, 4'b0000, 1'b1, 2'd2);
        rdd[2] = 32'h22;
        drive(4'b1100, 4'b1100, 3'd2, 4'b0100, 1'b1, 2'd2);
        drive(4'b1000, 4'b1000, 3'd7, 4'b1000, 1'b0, 2'd0);
        drive('0, '0, 3'd7, '0, 1'b0, 2'd0);

        // Read-during-write on addr 3.
        ra[0] = 3'd3; rdd[0] = 32'h11;
        drive(4'b0001, 4'b0001, 3'd3, 4'b0001, 1'b0, 2'd0);
        ra[1] = 3'd3; rdd[1] = 32'h22;
        drive(4'b0010, 4'b0010, 3'd3, 4'b0010, 1'b0, 2'd0);
        drive('0, '0, 3'd3, '0, 1'b0, 2'd0);

        // Async reset in the middle of a req0 burst.
        ra[0] = 3'd4; rdd[0] = 32'h55;
        drive(4'b0001, 4'b0000, 3'd4, 4'b0001, 1'b0, 2'd0);
        @(negedge clk);
        rdd[0] = 32'h56; ra[1] = 3'd1; rdd[1] = 32'h99;
        bus.req_data[0 +: NB]   = rdd[0];
        bus.req_addr[AW +: AW]  = ra[1];
        bus.req_data[NB +: NB]  = rdd[1];
        bus.req_val  = 4'b0011;
        bus.req_last = 4'b0000;
        #1;
        check_val("pre_rst_locked", 64'(bus.locked), 64'h1);
        check_val("pre_rst_rdy", 64'(bus.req_rdy), 64'h1);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_rst_locked", 64'(bus.locked), 64'h0);
        check_val("mid_rst_owner", 64'(bus.lock_owner), 64'h0);
        check_val("mid_rst_rdy", 64'(bus.req_rdy), 64'h0);
        for (int i = 0; i < NG; i++) m_bank[i] = '0;
        @(posedge clk);
        @(negedge clk);
        bus.req_val = '0;
        reset_n = 1'b1;
        drive(4'b0010, 4'b0010, 3'd4, 4'b0010, 1'b0, 2'd0);
        drive('0, '0, 3'd1, '0, 1'b0, 2'd0);
        drive('0, '0, 3'd3, '0, 1'b0, 2'd0);

        @(negedge clk);
        #3;
        check_val("sb_empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
